// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART blocks (receiver now, transmitter later).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam logic LINE_IDLE = 1'b1;

    // Counter width for a range of n values; never narrower than one bit so DIV=1 still builds.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic xor_reduce9(input logic [8:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick: one-cycle pulse every DIV clocks (every clock when DIV=1).
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    import uart_pkg::*;

    localparam int            CNT_W = cnt_width(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_LAST);

    // Next count: wrap at DIV-1.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with one-entry valid/ready holding register.
// Optional parity checking is built when UART_RX_PARITY_EN is defined.
module uart_rx_os #(
    parameter int DIV       = 27,
    parameter int OS        = 16,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
`ifdef UART_RX_PARITY_EN
    ,
    parameter int PARITY_ODD = 0
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);
    import uart_pkg::*;

    localparam int               OS_W      = cnt_width(OS);
    localparam logic [OS_W-1:0]  OS_HALF   = OS_W'(OS / 2 - 1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OS - 1);
    localparam logic [OS_W-1:0]  OS_ONE    = OS_W'(1);
    localparam int               BIT_W     = cnt_width(DATA_BITS + 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);

    logic tick;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    logic                 sync1_q, sync2_q, prev_q, prev_d;
    logic                 rxd_s;
    rx_state_t            state_q, state_d;
    logic [OS_W-1:0]      os_q, os_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 ferr_q, ferr_d;
    logic                 done_s;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
    logic                 perr_q, perr_d;
    logic                 parity_err_q, parity_err_d;
    logic [8:0]           shift_pad_s;
`endif

    assign rxd_s = sync2_q;

`ifdef UART_RX_PARITY_EN
    // Zero-extend the data word so one 9-bit parity helper covers every DATA_BITS.
    always_comb begin
        shift_pad_s = 9'd0;
        shift_pad_s[DATA_BITS-1:0] = shift_q;
    end
`endif

    // Frame FSM: all line decisions happen on tick cycles only.
    always_comb begin
        state_d = state_q;
        os_d    = os_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        ferr_d  = ferr_q;
        done_s  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d  = perr_q;
`endif
        prev_d  = tick ? rxd_s : prev_q;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    // Falling edge only: a held-low line must be seen high before re-arming.
                    if (prev_q && !rxd_s) begin
                        state_d = START;
                        os_d    = {OS_W{1'b0}};
                        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
                        perr_d  = 1'b0;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
                START: begin
                    if (os_q == OS_HALF) begin
                        if (!rxd_s) begin
                            state_d = DATA;
                            os_d    = {OS_W{1'b0}};
                            bit_d   = {BIT_W{1'b0}};
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        os_d = os_q + OS_ONE;
                    end
                end
                DATA: begin
                    if (os_q == OS_LAST) begin
                        shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                        os_d    = {OS_W{1'b0}};
                        if (bit_q == BIT_LAST) begin
                            bit_d = {BIT_W{1'b0}};
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_d = bit_q + BIT_ONE;
                        end
                    end else begin
                        os_d = os_q + OS_ONE;
                    end
                end
                PARITY: begin
`ifdef UART_RX_PARITY_EN
                    if (os_q == OS_LAST) begin
                        perr_d  = xor_reduce9(shift_pad_s) ^ rxd_s ^ 1'(PARITY_ODD);
                        os_d    = {OS_W{1'b0}};
                        state_d = STOP;
                    end else begin
                        os_d = os_q + OS_ONE;
                    end
`else
                    state_d = IDLE;
`endif
                end
                STOP: begin
                    if (os_q == OS_LAST) begin
                        if (!rxd_s) begin
                            ferr_d = 1'b1;
                        end else begin
                            ferr_d = ferr_q;
                        end
                        os_d = {OS_W{1'b0}};
                        if (bit_q == STOP_LAST) begin
                            bit_d   = {BIT_W{1'b0}};
                            state_d = IDLE;
                            done_s  = 1'b1;
                        end else begin
                            bit_d = bit_q + BIT_ONE;
                        end
                    end else begin
                        os_d = os_q + OS_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Holding register: a completion into a full, unaccepted register is dropped and flagged.
    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = frame_err_q;
        overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_d = parity_err_q;
`endif
        if (done_s) begin
            if (!valid_q || rx_ready) begin
                data_d      = shift_q;
                frame_err_d = ferr_d;
                valid_d     = 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_err_d = perr_q;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= LINE_IDLE;
            sync2_q     <= LINE_IDLE;
            prev_q      <= LINE_IDLE;
            state_q     <= IDLE;
            os_q        <= {OS_W{1'b0}};
            bit_q       <= {BIT_W{1'b0}};
            shift_q     <= {DATA_BITS{1'b0}};
            ferr_q      <= 1'b0;
            data_q      <= {DATA_BITS{1'b0}};
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q       <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync1_q     <= rxd;
            sync2_q     <= sync1_q;
            prev_q      <= prev_d;
            state_q     <= state_d;
            os_q        <= os_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            ferr_q      <= ferr_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
            perr_q       <= perr_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: serial frames driven bit by bit, checked against a frame-level model.
module tb_uart_rx_os;

    localparam int DIV     = 4;
    localparam int OS      = 16;
    localparam int DB      = 8;
    localparam int SB      = 1;
    localparam int BIT_CLK = DIV * OS;
`ifdef UART_RX_PARITY_EN
    localparam int PB   = 1;
    localparam int PODD = 0;
`else
    localparam int PB   = 0;
    localparam int PODD = 0;
`endif
    // Mid-point of the last stop bit, measured from the start edge.
    localparam int LAT_NOM = (DB + PB + SB) * BIT_CLK + BIT_CLK / 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rxd = 1'b1;
    logic          rx_ready = 1'b1;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          overrun;
    logic          busy;
`ifdef UART_RX_PARITY_EN
    logic          parity_err;
`endif

    always #5 clk = ~clk;

    uart_rx_os #(
        .DIV(DIV), .OS(OS), .DATA_BITS(DB), .STOP_BITS(SB)
`ifdef UART_RX_PARITY_EN
        , .PARITY_ODD(PODD)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy      (busy)
    );

    int cyc_p = 0;
    always @(posedge clk) cyc_p <= cyc_p + 1;

    // Observed delivery events, sampled mid-cycle.
    int            rises = 0;
    int            ovr_cnt = 0;
    int            cap_time = 0;
    logic [DB-1:0] cap_data = '0;
    logic          cap_ferr = 1'b0;
    logic          cap_perr = 1'b0;
    logic          vprev = 1'b0;
    always @(negedge clk) begin
        if (rx_valid && !vprev) begin
            rises    = rises + 1;
            cap_time = cyc_p;
            cap_data = rx_data;
            cap_ferr = frame_err;
`ifdef UART_RX_PARITY_EN
            cap_perr = parity_err;
`endif
        end
        if (overrun) ovr_cnt = ovr_cnt + 1;
        vprev = rx_valid;
    end

    int checks = 0;
    int failures = 0;

    // Frame-level model of the holding register.
    logic          model_full = 1'b0;
    int            exp_rises = 0;
    int            exp_ovr = 0;
    logic [DB-1:0] exp_data = '0;
    logic          exp_ferr = 1'b0;
    logic          exp_perr = 1'b0;
    int            t_start = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        checks = checks + 1;
        assert (obs >= lo && obs <= hi) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop_v, input logic hold_low);
        @(negedge clk);
        rxd = 1'b0;
        t_start = cyc_p;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < DB; i++) begin
            rxd = d[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        if (PB == 1) begin
            rxd = par;
            repeat (BIT_CLK) @(negedge clk);
        end
        rxd = stop_v;
        repeat (BIT_CLK * SB) @(negedge clk);
        rxd = hold_low ? 1'b0 : 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Send one frame, advance the model, and compare what the receiver delivered.
    task automatic frame_and_check(input string tag, input logic [7:0] d, input logic par,
                                   input logic stop_v, input logic hold_low);
        logic delivered;
        delivered = 1'b0;
        send_frame(d, par, stop_v, hold_low);
        if (!model_full || rx_ready) begin
            exp_data = d;
            exp_ferr = ~stop_v;
            exp_perr = (^d) ^ par ^ 1'(PODD);
            if (!model_full) begin
                exp_rises = exp_rises + 1;
                delivered = 1'b1;
            end
            model_full = ~rx_ready;
        end else begin
            exp_ovr = exp_ovr + 1;
        end
        check({tag, "_rises"}, rises, exp_rises);
        check({tag, "_overrun"}, ovr_cnt, exp_ovr);
        check({tag, "_data"}, {24'd0, cap_data}, {24'd0, exp_data});
        check({tag, "_ferr"}, {31'd0, cap_ferr}, {31'd0, exp_ferr});
`ifdef UART_RX_PARITY_EN
        check({tag, "_perr"}, {31'd0, cap_perr}, {31'd0, exp_perr});
`endif
        if (delivered) check_range({tag, "_latency"}, cap_time - t_start, LAT_NOM, LAT_NOM + 12);
    endtask

    initial begin
        logic [7:0] rd;
        logic       rp;
        logic       rs;

        // Reset state.
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_data", {24'd0, rx_data}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        repeat (20) @(negedge clk);

        // Basic 8N1 frame.
        frame_and_check("a5", 8'hA5, 1'b0, 1'b1, 1'b0);
        check("a5_valid_pulse", {31'd0, rx_valid}, 32'd0);

        // Random words, parity bits and occasional bad stop bits.
        for (int k = 0; k < 6; k++) begin
            rd = 8'($urandom);
            rp = 1'($urandom);
            rs = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            frame_and_check("rand", rd, rp, rs, 1'b0);
        end

        // Short low glitch: false start, no output.
        @(negedge clk);
        rxd = 1'b0;
        repeat (12) @(negedge clk);
        check("glitch_busy_hi", {31'd0, busy}, 32'd1);
        repeat (8) @(negedge clk);
        rxd = 1'b1;
        repeat (100) @(negedge clk);
        check("glitch_busy_lo", {31'd0, busy}, 32'd0);
        check("glitch_rises", rises, exp_rises);

        // Framing error, then break: no re-arm while low.
        frame_and_check("ferr3c", 8'h3C, 1'b0, 1'b0, 1'b1);
        repeat (2000) @(negedge clk);
        check("break_rises", rises, exp_rises);
        check("break_busy", {31'd0, busy}, 32'd0);
        rxd = 1'b1;
        repeat (50) @(negedge clk);
        frame_and_check("after_break", 8'h81, 1'b1, 1'b1, 1'b0);

        // Overrun: second word dropped while first is held.
        rx_ready = 1'b0;
        frame_and_check("ovr11", 8'h11, 1'b0, 1'b1, 1'b0);
        check("ovr11_valid", {31'd0, rx_valid}, {31'd0, model_full});
        frame_and_check("ovr22", 8'h22, 1'b0, 1'b1, 1'b0);
        check("ovr22_held_data", {24'd0, rx_data}, {24'd0, exp_data});
        check("ovr22_valid", {31'd0, rx_valid}, 32'd1);
        rx_ready = 1'b1;
        model_full = 1'b0;
        @(negedge clk);
        check("ovr_release", {31'd0, rx_valid}, 32'd0);
        repeat (20) @(negedge clk);

        // Reset in the middle of data bit 4; aborted frame must leave no trace.
        @(negedge clk);
        rxd = 1'b0;
        repeat (BIT_CLK * 5) @(negedge clk);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_valid", {31'd0, rx_valid}, 32'd0);
        check("abort_data", {24'd0, rx_data}, 32'd0);
        repeat (700) @(negedge clk);
        check("abort_rises", rises, exp_rises);
        frame_and_check("after_abort", 8'h5A, 1'b0, 1'b1, 1'b0);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones.
        frame_and_check("par07_p0", 8'h07, 1'b0, 1'b1, 1'b0);
        check("par07_p0_flag", {31'd0, cap_perr}, 32'd1);
        frame_and_check("par07_p1", 8'h07, 1'b1, 1'b1, 1'b0);
        check("par07_p1_flag", {31'd0, cap_perr}, 32'd0);
`endif

        repeat (20) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
